// File: rtl/display_overlay_scheduler.sv
// Picks the 7-segment view: time (0) or one of NUM_SRC prioritised, queued overlays held for HOLD_TICKS ticks.
// Optional end-of-hold blink output is built only when OVERLAY_BLINK_EN is defined.
module display_overlay_scheduler #(
  parameter int NUM_SRC     = 3,
  parameter int SEL_W       = 2,
  parameter int CNT_W       = 28,
  parameter int HOLD_TICKS  = 500,
  parameter int BLINK_TICKS = 100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic [NUM_SRC-1:0] events,
  output logic [SEL_W-1:0]   display_select,
  output logic               overlay_active,
  output logic [CNT_W-1:0]   remaining,
`ifdef OVERLAY_BLINK_EN
  output logic               blink,
`endif
  output logic               timeout
);

  if ((1 << SEL_W) < NUM_SRC + 1 || HOLD_TICKS < 1 || BLINK_TICKS < 0)
    $error("display_overlay_scheduler: bad parameters");

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state;
  logic [SEL_W-1:0]   act;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] req;
  logic [SEL_W-1:0]   w_req, w_ev, w_pend;

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_TICKS);

  function automatic logic [SEL_W-1:0] lowest(input logic [NUM_SRC-1:0] v);
    lowest = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (v[i]) lowest = SEL_W'(i);
  endfunction

  function automatic logic [NUM_SRC-1:0] bit_of(input logic [SEL_W-1:0] i);
    bit_of = NUM_SRC'(1) << i;
  endfunction

  always_comb begin
    req    = events | pending;
    w_req  = lowest(req);
    w_ev   = lowest(events);
    w_pend = lowest(pending);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      act            <= '0;
      pending        <= '0;
      display_select <= '0;
      overlay_active <= 1'b0;
      remaining      <= '0;
      timeout        <= 1'b0;
`ifdef OVERLAY_BLINK_EN
      blink          <= 1'b0;
`endif
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: if (req != '0) begin
          state          <= HOLD;
          act            <= w_req;
          display_select <= w_req + SEL_W'(1);
          overlay_active <= 1'b1;
          remaining      <= HOLD_LD;
          pending        <= req & ~bit_of(w_req);
`ifdef OVERLAY_BLINK_EN
          blink          <= 1'b0;
`endif
        end
        HOLD: if (events != '0) begin
          // Preempt or retrigger reloads; the displaced source is simply dropped.
          if (w_ev <= act) begin
            act            <= w_ev;
            display_select <= w_ev + SEL_W'(1);
            remaining      <= HOLD_LD;
            pending        <= (pending | events) & ~bit_of(w_ev);
`ifdef OVERLAY_BLINK_EN
            blink          <= 1'b0;
`endif
          end else begin
            pending <= pending | events;
          end
        end else if (tick) begin
          if (remaining > CNT_W'(1)) begin
            remaining <= remaining - CNT_W'(1);
`ifdef OVERLAY_BLINK_EN
            if (remaining <= CNT_W'(BLINK_TICKS)) blink <= ~blink;
`endif
          end else if (pending != '0) begin
            act            <= w_pend;
            display_select <= w_pend + SEL_W'(1);
            remaining      <= HOLD_LD;
            pending        <= pending & ~bit_of(w_pend);
`ifdef OVERLAY_BLINK_EN
            blink          <= 1'b0;
`endif
          end else begin
            state          <= IDLE;
            display_select <= '0;
            overlay_active <= 1'b0;
            remaining      <= '0;
            timeout        <= 1'b1;
`ifdef OVERLAY_BLINK_EN
            blink          <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
